pipelined_mult_acc: RTL and testbench
=====================================

PIPELINED_MULT_ACC -- requirements
Module: pipelined_mult_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, full-mode operand width; even, >= 4.
REQ-002 SHALL have parameter HALF, fixed at WIDTH/2, the split-lane operand width; not user-overridable.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port a_i  input  WIDTH  operand A, two's complement; lane0 = [HALF-1:0], lane1 = [WIDTH-1:HALF].
REQ-006 SHALL have port b_i  input  WIDTH  operand B, same packing as a_i.
REQ-007 SHALL have port valid_i  input  2  per-lane issue strobe; full mode uses bit 0 and ignores bit 1.
REQ-008 SHALL have port split_i  input  1  mode select: 0 = one WIDTHxWIDTH multiply, 1 = two HALFxHALF multiplies.
REQ-009 SHALL have port acc_en_i  input  1  accumulate select: 1 = add product to accumulator, 0 = load product.
REQ-010 SHALL have port clear_i  input  1  synchronous accumulator and overflow clear.
REQ-011 SHALL have port c_o  output  2*WIDTH  result; split mode packs lane1 in [2W-1:W] and lane0 in [W-1:0].
REQ-012 SHALL have port valid_o  output  2  per-lane result strobe, one-cycle pulse.
REQ-013 SHALL have port ovf_o  output  2  sticky signed-overflow flag per lane; full mode uses bit 0.

Function
REQ-014 SHALL register a_i, b_i, split_i and acc_en_i in stage 1 on any cycle where a used valid_i bit is 1; otherwise stage 1 SHALL hold.
REQ-015 SHALL register the product or accumulation in stage 2, so valid_o pulses exactly 2 cycles after the valid_i sample; latency is fixed and there is no backpressure.
REQ-016 SHALL accept back-to-back issues every cycle at full throughput.
REQ-017 SHALL use the mode captured in stage 1 for in-flight operations; a split_i change never corrupts issued operations.
REQ-018 Full mode: SHALL compute signed A*B to 2*WIDTH bits, then sum = acc + product (mod 2^(2W)) when acc_en is set, else sum = product; the result is written to c_o and valid_o = 2'b01.
REQ-019 Split mode: each lane SHALL compute signed HALF*HALF to WIDTH bits and accumulate mod 2^W, with no carry between lanes.
REQ-020 Split mode: only lanes whose valid bit was set SHALL update and pulse valid_o; the other lane SHALL hold its c_o slice.
REQ-021 SHALL set ovf_o[lane] when an accumulate adds two same-sign values and the result sign differs; the bit stays set until clear_i or reset.
REQ-022 clear_i SHALL zero all accumulators (c_o) and ovf_o at the next edge.
REQ-023 If clear_i coincides with a completing stage-2 update, that update SHALL be treated as acc_en = 0 (c_o = product, ovf unchanged from 0), and valid_o SHALL still pulse.
REQ-024 On a split-mode change, the first completing op in the new mode SHALL treat accumulator contents as the raw c_o bit slices; no reinterpretation is applied.
REQ-025 Between valid_o pulses, c_o SHALL hold its last value.

Reset
REQ-026 reset SHALL have priority over all inputs; at the next edge c_o = 0, valid_o = 2'b00, ovf_o = 2'b00, and stage-1 registers = 0.
REQ-027 Reset asserted mid-flight SHALL discard in-flight operations; no valid_o pulse for them after reset deasserts.
REQ-028 The first valid_i sampled after reset deasserts SHALL produce a normal 2-cycle-latency result.

Verification (WIDTH=32 unless noted)
REQ-029 Full mode: a=-3, b=7, acc_en=0, valid_i=01 -> two cycles later c_o=64'hFFFF_FFFF_FFFF_FFEB, valid_o=01.
REQ-030 Split mode: a={16'd5,-16'sd2}, b={16'd3,16'd4}, valid_i=11, acc_en=0 then 1 on the next cycle -> c_o lanes {15,-8}, then {30,-16}, on consecutive cycles.
REQ-031 Split mode, lane-1 overflow: set lane1 to 32'h7FFF_FFFF, then accumulate product 1 -> lane1 = 32'h8000_0000, ovf_o=10, lane0 unchanged.
REQ-032 Clear collision: clear_i asserted in the same cycle a product of 6 completes with acc_en=1 -> c_o=6, ovf_o=00, valid_o pulses.
REQ-033 reset asserted one cycle after valid_i -> no valid_o pulse; c_o=0 for 3 cycles; the next issue of 2*2 yields c_o=4 at latency 2.
REQ-034 WIDTH=8: full mode with 100 random back-to-back issues and mixed acc_en, compared against a signed reference model every cycle.

Source files
------------

// File: rtl/pipelined_mult_acc.sv
// Two-stage signed multiply-accumulate. It runs either one WIDTHxWIDTH lane or two independent
// HALFxHALF lanes, with sticky per-lane signed-overflow flags.
module pipelined_mult_acc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic [1:0]           valid_i,
  input  logic                 split_i,
  input  logic                 acc_en_i,
  input  logic                 clear_i,
  output logic [2*WIDTH-1:0]   c_o,
  output logic [1:0]           valid_o,
  output logic [1:0]           ovf_o
);

  localparam int unsigned HALF = WIDTH / 2;

  logic [WIDTH-1:0]   a_q, b_q;
  logic               split_q, acc_en_q;
  logic [1:0]         issue, vld_q;

  logic [2*WIDTH-1:0] prod_full, sum_full;
  logic [WIDTH-1:0]   prod_lo, prod_hi, sum_lo, sum_hi;
  logic               acc_use;

  logic [2*WIDTH-1:0] c_d, c_q;
  logic [1:0]         ovf_d, ovf_q, valid_d;

  // Same-sign operands producing a result of the opposite sign.
  function automatic logic add_ovf(input logic x, input logic y, input logic s);
    return (x == y) && (s != x);
  endfunction

  always_comb begin
    issue = split_i ? valid_i : {1'b0, valid_i[0]};
  end

  // Stage 1: operands and mode are held unless a lane issues; the lane mask always advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      split_q  <= 1'b0;
      acc_en_q <= 1'b0;
      vld_q    <= 2'b00;
    end else begin
      vld_q <= issue;
      if (|issue) begin
        a_q      <= a_i;
        b_q      <= b_i;
        split_q  <= split_i;
        acc_en_q <= acc_en_i;
      end
    end
  end

  // Operands are sign-extended to the result width, so truncated products are exact.
  always_comb begin
    prod_full = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    prod_lo   = $signed({{HALF{a_q[HALF-1]}}, a_q[HALF-1:0]}) *
                $signed({{HALF{b_q[HALF-1]}}, b_q[HALF-1:0]});
    prod_hi   = $signed({{HALF{a_q[WIDTH-1]}}, a_q[WIDTH-1:HALF]}) *
                $signed({{HALF{b_q[WIDTH-1]}}, b_q[WIDTH-1:HALF]});
  end

  // A clear landing on a completing op turns it into a load.
  always_comb begin
    acc_use  = acc_en_q & ~clear_i;
    sum_full = acc_use ? c_q + prod_full : prod_full;
    sum_lo   = acc_use ? c_q[WIDTH-1:0] + prod_lo : prod_lo;
    sum_hi   = acc_use ? c_q[2*WIDTH-1:WIDTH] + prod_hi : prod_hi;

    c_d     = clear_i ? '0 : c_q;
    ovf_d   = clear_i ? 2'b00 : ovf_q;
    valid_d = 2'b00;

    if (!split_q) begin
      if (vld_q[0]) begin
        c_d     = sum_full;
        valid_d = 2'b01;
        if (acc_use && add_ovf(c_q[2*WIDTH-1], prod_full[2*WIDTH-1], sum_full[2*WIDTH-1])) begin
          ovf_d[0] = 1'b1;
        end
      end
    end else begin
      if (vld_q[0]) begin
        c_d[WIDTH-1:0] = sum_lo;
        valid_d[0]     = 1'b1;
        if (acc_use && add_ovf(c_q[WIDTH-1], prod_lo[WIDTH-1], sum_lo[WIDTH-1])) begin
          ovf_d[0] = 1'b1;
        end
      end
      if (vld_q[1]) begin
        c_d[2*WIDTH-1:WIDTH] = sum_hi;
        valid_d[1]           = 1'b1;
        if (acc_use && add_ovf(c_q[2*WIDTH-1], prod_hi[WIDTH-1], sum_hi[WIDTH-1])) begin
          ovf_d[1] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_q     <= '0;
      ovf_q   <= 2'b00;
      valid_o <= 2'b00;
    end else begin
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      valid_o <= valid_d;
    end
  end

  assign c_o   = c_q;
  assign ovf_o = ovf_q;

endmodule

// File: tb/tb_pipelined_mult_acc.sv
// Bench for pipelined_mult_acc: an arithmetic reference model checked every cycle for a 32-bit
// and an 8-bit instance, plus directed vectors with hand-computed results.
module tb_pipelined_mult_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst32 = 1'b1;
  logic [31:0] a32 = '0, b32 = '0;
  logic [1:0]  v32 = '0;
  logic        sp32 = 1'b0, acc32 = 1'b0, clr32 = 1'b0;
  logic [63:0] c32;
  logic [1:0]  vo32, ovf32;

  logic        rst8 = 1'b1;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [1:0]  v8 = '0;
  logic        sp8 = 1'b0, acc8 = 1'b0, clr8 = 1'b0;
  logic [15:0] c8;
  logic [1:0]  vo8, ovf8;

  int n_chk = 0;
  int n_fail = 0;

  pipelined_mult_acc #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(rst32), .a_i(a32), .b_i(b32), .valid_i(v32), .split_i(sp32),
    .acc_en_i(acc32), .clear_i(clr32), .c_o(c32), .valid_o(vo32), .ovf_o(ovf32)
  );

  pipelined_mult_acc #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst8), .a_i(a8), .b_i(b8), .valid_i(v8), .split_i(sp8),
    .acc_en_i(acc8), .clear_i(clr8), .c_o(c8), .valid_o(vo8), .ovf_o(ovf8)
  );

  typedef struct packed {
    logic        pend;
    logic [1:0]  mask;
    logic        split;
    logic        acc;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  typedef struct packed {
    logic [63:0] c;
    logic [1:0]  ovf;
    logic [1:0]  vo;
    op_t         st1;
  } mdl_t;

  mdl_t m32 = '0;
  mdl_t m8 = '0;

  function automatic logic signed [127:0] sx(input logic [63:0] v, input int n);
    logic signed [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = (i < n) ? v[i] : v[n-1];
    return r;
  endfunction

  // n-bit signed operands, 2n-bit result; overflow means the true sum leaves the 2n-bit range.
  function automatic logic [64:0] lane_calc(input logic [63:0] acc_v, input logic [63:0] a,
                                            input logic [63:0] b, input int n, input logic da);
    logic signed [127:0] p, s, lim;
    logic [63:0] r;
    p   = sx(a, n) * sx(b, n);
    s   = da ? sx(acc_v, 2 * n) + p : p;
    lim = 128'sd1 <<< (2 * n - 1);
    r   = '0;
    for (int i = 0; i < 2 * n; i++) r[i] = s[i];
    return {da && (s >= lim || s < -lim), r};
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input int w, input logic rst,
                                    input logic [1:0] v, input logic sp, input logic acc,
                                    input logic clr, input logic [31:0] a, input logic [31:0] b);
    mdl_t n;
    logic [64:0] lr;
    logic [63:0] wmask;
    logic da;
    int h;
    n = m;
    h = w / 2;
    n.vo = 2'b00;
    if (rst) begin
      n.c = '0;
      n.ovf = 2'b00;
      n.st1 = '0;
      return n;
    end
    if (clr) begin
      n.c = '0;
      n.ovf = 2'b00;
    end
    da = m.st1.acc && !clr;
    if (m.st1.pend) begin
      if (!m.st1.split) begin
        lr = lane_calc(n.c, 64'(m.st1.a), 64'(m.st1.b), w, da);
        n.c = lr[63:0];
        n.ovf[0] = n.ovf[0] | lr[64];
        n.vo = 2'b01;
      end else begin
        wmask = (64'd1 << w) - 64'd1;
        for (int l = 0; l < 2; l++) begin
          if (m.st1.mask[l]) begin
            lr = lane_calc(n.c >> (l * w), 64'(m.st1.a >> (l * h)), 64'(m.st1.b >> (l * h)),
                           h, da);
            n.c = (n.c & ~(wmask << (l * w))) | ((lr[63:0] & wmask) << (l * w));
            n.ovf[l] = n.ovf[l] | lr[64];
            n.vo[l] = 1'b1;
          end
        end
      end
    end
    n.st1.mask = sp ? v : {1'b0, v[0]};
    n.st1.pend = |n.st1.mask;
    if (n.st1.pend) begin
      n.st1.a = a;
      n.st1.b = b;
      n.st1.split = sp;
      n.st1.acc = acc;
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Model advances on each rising edge; outputs are compared 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      m32 = mdl_step(m32, 32, rst32, v32, sp32, acc32, clr32, a32, b32);
      m8  = mdl_step(m8, 8, rst8, v8, sp8, acc8, clr8, {24'b0, a8}, {24'b0, b8});
      #1;
      chk("mdl_c32", c32, m32.c);
      chk("mdl_vo32", 64'(vo32), 64'(m32.vo));
      chk("mdl_ovf32", 64'(ovf32), 64'(m32.ovf));
      chk("mdl_c8", 64'(c8), 64'(m8.c[15:0]));
      chk("mdl_vo8", 64'(vo8), 64'(m8.vo));
      chk("mdl_ovf8", 64'(ovf8), 64'(m8.ovf));
    end
  end

  initial begin
    repeat (2) tick();
    chk("rst_c", c32, 64'h0);
    chk("rst_vo", 64'(vo32), 64'h0);
    chk("rst_ovf", 64'(ovf32), 64'h0);
    rst32 = 1'b0;
    rst8  = 1'b0;
    tick();

    // Full mode -3*7; split_i flips while the op is in flight.
    a32 = 32'hFFFF_FFFD; b32 = 32'd7; sp32 = 1'b0; acc32 = 1'b0; v32 = 2'b01;
    tick();
    v32 = 2'b00; sp32 = 1'b1;
    tick();
    chk("full_neg_c", c32, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("full_neg_vo", 64'(vo32), 64'h1);

    // Split mode back-to-back: load then accumulate.
    a32 = 32'h0005_FFFE; b32 = 32'h0003_0004; acc32 = 1'b0; v32 = 2'b11;
    tick();
    acc32 = 1'b1;
    tick();
    v32 = 2'b00;
    chk("split_load_c", c32, 64'h0000_000F_FFFF_FFF8);
    chk("split_load_vo", 64'(vo32), 64'h3);
    tick();
    chk("split_acc_c", c32, 64'h0000_001E_FFFF_FFF0);

    // Lane-1 overflow: build 0x7FFFFFFF then add 1; lane 0 stays idle.
    clr32 = 1'b1;
    tick();
    clr32 = 1'b0;
    v32 = 2'b10; acc32 = 1'b0; a32 = 32'h8000_1234; b32 = 32'h8000_4321;
    tick();
    acc32 = 1'b1; a32 = 32'h7FFF_1234; b32 = 32'h7FFF_4321;
    tick();
    a32 = 32'h0002_1234; b32 = 32'h7FFF_4321;
    tick();
    a32 = 32'h0001_1234; b32 = 32'h0001_4321;
    tick();
    v32 = 2'b00;
    tick();
    chk("ovf_lane1_c", c32, 64'h8000_0000_0000_0000);
    chk("ovf_lane1_flag", 64'(ovf32), 64'h2);
    v32 = 2'b10;
    tick();
    v32 = 2'b00;
    tick();
    chk("ovf_sticky_c", c32, 64'h8000_0001_0000_0000);
    chk("ovf_sticky_flag", 64'(ovf32), 64'h2);

    // Clear collides with a completing accumulate of 2*3.
    sp32 = 1'b0; a32 = 32'd2; b32 = 32'd3; acc32 = 1'b1; v32 = 2'b01;
    tick();
    v32 = 2'b00; clr32 = 1'b1;
    tick();
    clr32 = 1'b0;
    chk("clr_col_c", c32, 64'd6);
    chk("clr_col_vo", 64'(vo32), 64'h1);
    chk("clr_col_ovf", 64'(ovf32), 64'h0);

    // Reset one cycle after issue discards the op.
    a32 = 32'd5; b32 = 32'd5; acc32 = 1'b0; v32 = 2'b01;
    tick();
    v32 = 2'b00; rst32 = 1'b1;
    tick();
    rst32 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_mid_c", c32, 64'h0);
      chk("rst_mid_vo", 64'(vo32), 64'h0);
      tick();
    end
    a32 = 32'd2; b32 = 32'd2; v32 = 2'b01;
    tick();
    v32 = 2'b00;
    tick();
    chk("post_rst_c", c32, 64'd4);
    chk("post_rst_vo", 64'(vo32), 64'h1);
    tick();
    chk("hold_c", c32, 64'd4);
    chk("hold_vo", 64'(vo32), 64'h0);
    a32 = 32'hFFFF_FFFF; b32 = 32'd3; acc32 = 1'b1; v32 = 2'b01;
    tick();
    v32 = 2'b00;
    tick();
    chk("full_acc_c", c32, 64'd1);

    // WIDTH=8: random back-to-back full-mode issues, then mixed split/valid traffic.
    for (int i = 0; i < 100; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      acc8 = 1'($urandom_range(0, 1));
      clr8 = ($urandom_range(0, 9) == 0);
      sp8 = 1'b0; v8 = 2'b01;
      tick();
    end
    for (int i = 0; i < 60; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      acc8 = 1'($urandom_range(0, 1));
      clr8 = ($urandom_range(0, 7) == 0);
      sp8 = 1'($urandom_range(0, 1));
      v8 = 2'($urandom_range(0, 3));
      rst8 = (i == 30);
      tick();
    end
    v8 = 2'b00; clr8 = 1'b0; rst8 = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
